// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS subset CPU: opcodes, function
// codes, FSM state codes, ALU operations and the packed control vector.
package mips_cpu_pkg;

  localparam logic [31:0] CODE_SEG_PC   = 32'h0000_3000;
  localparam logic [4:0]  REG_ADDR_FLAG = 5'd30;
  localparam logic [4:0]  REG_ADDR_RET  = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [2:0] {
    S1 = 3'd0,  // fetch
    S2 = 3'd1,  // decode / register read / branch resolve
    S3 = 3'd2,  // execute
    S4 = 3'd3,  // memory
    S5 = 3'd4   // write back
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_SLT = 3'd3,
    ALU_LUI = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;    // result goes to the register file in S5
    logic    reg_dst_rd;   // destination is rd (R-type) instead of rt
    logic    alu_src_imm;  // ALU operand B is the extended immediate
    logic    ext_sign;     // sign-extend imm16 (otherwise zero-extend)
    alu_op_t alu_op;
    logic    mem_write;
    logic    mem_to_reg;   // write-back data comes from memory
    logic    ovf_check;    // signed overflow suppresses the write, sets flag
    logic    beq;
    logic    jump;         // j and jal
    logic    link;         // jal: save return address
    logic    jr;
  } ctrl_t;

endpackage

// File: rtl/mips_cpu_if.sv
// Data-memory bus between the CPU datapath and the data memory.
interface mips_cpu_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mips_cpu_ctr.sv
// Controller: instruction decode into per-mnemonic flags and the packed
// control vector, plus the five-state multi-cycle sequencing FSM.
module mips_cpu_ctr import mips_cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output state_t      status,
  output ctrl_t       signals
);
  logic [5:0] op;
  logic [5:0] fn;
  logic       rtype;
  logic       addu, subu, slt, jr, ori, lui, addi, addiu, lw, sw, beq, j, jal, nop;
  logic       alu_class;
  logic       needs_exec;
  state_t     next_status;

  assign op    = instruction[31:26];
  assign fn    = instruction[5:0];
  assign rtype = (op == OP_RTYPE);
  assign nop   = (instruction == 32'h0000_0000);

  assign addu  = rtype && (fn == FN_ADDU);
  assign subu  = rtype && (fn == FN_SUBU);
  assign slt   = rtype && (fn == FN_SLT);
  assign jr    = rtype && (fn == FN_JR);
  assign ori   = (op == OP_ORI);
  assign lui   = (op == OP_LUI);
  assign addi  = (op == OP_ADDI);
  assign addiu = (op == OP_ADDIU);
  assign lw    = (op == OP_LW);
  assign sw    = (op == OP_SW);
  assign beq   = (op == OP_BEQ);
  assign j     = (op == OP_J);
  assign jal   = (op == OP_JAL);

  // anything not recognised here finishes in S2 and so behaves as a nop
  assign alu_class  = addu || subu || slt || ori || lui || addi || addiu;
  assign needs_exec = !nop && (alu_class || lw || sw);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status <= S1;
    else      status <= next_status;
  end

  // next-state sequencing
  always_comb begin
    next_status = S1;
    case (status)
      S1:      next_status = S2;
      S2:      next_status = needs_exec ? S3 : S1;
      S3:      next_status = (lw || sw) ? S4 : S5;
      S4:      next_status = lw ? S5 : S1;
      S5:      next_status = S1;
      default: next_status = S1;
    endcase
  end

  // control vector, derived from IR and therefore stable from S2 to next S1
  always_comb begin
    signals             = '0;
    signals.reg_write   = alu_class || lw;
    signals.reg_dst_rd  = addu || subu || slt;
    signals.alu_src_imm = !(addu || subu || slt);
    signals.ext_sign    = addi || addiu || lw || sw;
    signals.mem_write   = sw;
    signals.mem_to_reg  = lw;
    signals.ovf_check   = addi;
    signals.beq         = beq;
    signals.jump        = j || jal;
    signals.link        = jal;
    signals.jr          = jr;
    if (subu)     signals.alu_op = ALU_SUB;
    else if (slt) signals.alu_op = ALU_SLT;
    else if (ori) signals.alu_op = ALU_OR;
    else if (lui) signals.alu_op = ALU_LUI;
    else          signals.alu_op = ALU_ADD;
  end
endmodule

// File: rtl/mips_cpu_units.sv
// Datapath building blocks: instruction memory, fetch unit, register file,
// ALU and data memory.

module mips_cpu_im #(
  parameter int IM_BYTES = 1024,
  localparam int AW = $clog2(IM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   word,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data
);
  logic [7:0] im [0:IM_BYTES-1];

  // byte load port; the CPU itself never writes code, contents are preloaded
  always_ff @(posedge clk) begin
    if (load_en) im[load_addr] <= load_data;
  end

  // instructions are stored big-endian
  assign word = {im[addr], im[addr + AW'(1)], im[addr + AW'(2)], im[addr + AW'(3)]};
endmodule

module mips_cpu_ifu #(
  parameter logic [31:0] CODE_SEG_PC = 32'h0000_3000,
  parameter int          IM_BYTES    = 1024,
  localparam int         AW          = $clog2(IM_BYTES)
) (
  input  logic        clk,
  input  logic [31:0] pc,
  output logic [31:0] word
);
  logic [31:0] offset;
  logic        unused_hi;

  assign offset    = pc - CODE_SEG_PC;
  assign unused_hi = ^offset[31:AW];

  mips_cpu_im #(.IM_BYTES(IM_BYTES)) im (
    .clk       (clk),
    .addr      (offset[AW-1:0]),
    .word      (word),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data (8'h00)
  );
endmodule

module mips_cpu_gpr import mips_cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        flag_we,
  input  logic        flag_val
);
  logic [31:0] regs [0:31];

  // register writes; r0 is never written so it always reads zero, and the
  // main port is applied after the flag port so an explicit rt write wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (flag_we) regs[REG_ADDR_FLAG] <= {31'b0, flag_val};
      if (we && (wa != 5'd0)) regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
endmodule

module mips_cpu_alu import mips_cpu_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic        ovf
);
  logic signed [31:0] sa;
  logic signed [31:0] sb;

  assign sa = a;
  assign sb = b;

  // result and signed-add overflow (only meaningful for ALU_ADD)
  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      ALU_ADD: begin
        y   = a + b;
        ovf = (a[31] == b[31]) && (y[31] != a[31]);
      end
      ALU_SUB: y = a - b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, (sa < sb)};
      ALU_LUI: y = {b[15:0], 16'h0000};
      default: y = '0;
    endcase
  end
endmodule

module mips_cpu_dm #(
  parameter int DM_BYTES = 1024,
  localparam int AW = $clog2(DM_BYTES)
) (
  input logic       clk,
  mips_cpu_if.slave bus
);
  logic [7:0]    dm [0:DM_BYTES-1];
  logic [AW-1:0] a;
  logic          unused_hi;

  assign a         = bus.addr[AW-1:0];
  assign unused_hi = ^bus.addr[31:AW];

  // little-endian word store
  always_ff @(posedge clk) begin
    if (bus.we) begin
      dm[a]          <= bus.wdata[7:0];
      dm[a + AW'(1)] <= bus.wdata[15:8];
      dm[a + AW'(2)] <= bus.wdata[23:16];
      dm[a + AW'(3)] <= bus.wdata[31:24];
    end
  end

  assign bus.rdata = {dm[a + AW'(3)], dm[a + AW'(2)], dm[a + AW'(1)], dm[a]};
endmodule

// File: rtl/mips_cpu.sv
// Multi-cycle, non-pipelined MIPS-32 subset CPU. PC and IR live here; the
// controller sequences S1..S5 and the datapath units do the work.
module mips_cpu #(
  parameter logic [31:0] CODE_SEG_PC = mips_cpu_pkg::CODE_SEG_PC,
  parameter int          IM_BYTES    = 1024,
  parameter int          DM_BYTES    = 1024
) (
  input logic clk,
  input logic rst
);
  import mips_cpu_pkg::*;

  logic [31:0] PC;
  logic [31:0] instruction;
  logic [31:0] im_word;
  logic [31:0] a_reg, b_reg, alu_out, mdr;
  logic        ovf_reg;
  logic [31:0] rd1, rd2;
  logic [31:0] imm_ext, alu_b, alu_y;
  logic        alu_ovf;
  logic [31:0] pc_branch, pc_jump;
  logic [4:0]  rs, rt, rd;
  logic        gpr_we, flag_we;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;
  state_t      status;
  ctrl_t       signals;

  mips_cpu_if dbus ();

  assign rs = instruction[25:21];
  assign rt = instruction[20:16];
  assign rd = instruction[15:11];

  assign imm_ext   = signals.ext_sign ? {{16{instruction[15]}}, instruction[15:0]}
                                      : {16'h0000, instruction[15:0]};
  assign alu_b     = signals.alu_src_imm ? imm_ext : b_reg;
  // PC has already been incremented in S1 when these are used in S2
  assign pc_branch = PC + {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign pc_jump   = {PC[31:28], instruction[25:0], 2'b00};

  assign dbus.addr  = alu_out;
  assign dbus.wdata = b_reg;
  assign dbus.we    = (status == S4) && signals.mem_write;

  mips_cpu_ifu #(.CODE_SEG_PC(CODE_SEG_PC), .IM_BYTES(IM_BYTES)) ifu (
    .clk  (clk),
    .pc   (PC),
    .word (im_word)
  );

  mips_cpu_ctr ctr (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .status      (status),
    .signals     (signals)
  );

  mips_cpu_gpr gpr (
    .clk      (clk),
    .rst      (rst),
    .ra1      (rs),
    .ra2      (rt),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (gpr_we),
    .wa       (gpr_wa),
    .wd       (gpr_wd),
    .flag_we  (flag_we),
    .flag_val (ovf_reg)
  );

  mips_cpu_alu alu (
    .a   (a_reg),
    .b   (alu_b),
    .op  (signals.alu_op),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  mips_cpu_dm #(.DM_BYTES(DM_BYTES)) dm (
    .clk (clk),
    .bus (dbus)
  );

  // fetch in S1, control transfers resolved in S2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC          <= CODE_SEG_PC;
      instruction <= '0;
    end else begin
      case (status)
        S1: begin
          instruction <= im_word;
          PC          <= PC + 32'd4;
        end
        S2: begin
          if (signals.jr)                        PC <= rd1;
          else if (signals.jump)                 PC <= pc_jump;
          else if (signals.beq && (rd1 == rd2))  PC <= pc_branch;
        end
        default: ;
      endcase
    end
  end

  // operand, ALU result and load data holding registers
  always_ff @(posedge clk) begin
    if (status == S2) begin
      a_reg <= rd1;
      b_reg <= rd2;
    end
    if (status == S3) begin
      alu_out <= alu_y;
      ovf_reg <= alu_ovf;
    end
    if (status == S4) mdr <= dbus.rdata;
  end

  // register-file write selection: jal links in S2, everything else in S5
  always_comb begin
    gpr_we  = 1'b0;
    gpr_wa  = rt;
    gpr_wd  = alu_out;
    flag_we = 1'b0;
    if ((status == S2) && signals.link) begin
      gpr_we = 1'b1;
      gpr_wa = REG_ADDR_RET;
      gpr_wd = PC;
    end else if (status == S5) begin
      gpr_we  = signals.reg_write && !(signals.ovf_check && ovf_reg);
      gpr_wa  = signals.reg_dst_rd ? rd : rt;
      gpr_wd  = signals.mem_to_reg ? mdr : alu_out;
      flag_we = signals.ovf_check;
    end
  end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: small programs are placed in instruction
// memory, run for an exact number of cycles and the state checked.
module tb_mips_cpu;
  import mips_cpu_pkg::*;

  logic        clk;
  logic        rst;
  int          tests;
  int          fails;
  logic [31:0] prog [$];

  mips_cpu dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic put_word(input int i, input logic [31:0] w);
    dut.ifu.im.im[4*i]     = w[31:24];
    dut.ifu.im.im[4*i + 1] = w[23:16];
    dut.ifu.im.im[4*i + 2] = w[15:8];
    dut.ifu.im.im[4*i + 3] = w[7:0];
  endtask

  // reset the CPU, load prog (rest nop) and release reset on a falling edge
  task automatic start();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) put_word(i, (i < prog.size()) ? prog[i] : 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;

    // ALU group
    prog = '{enc_i(OP_LUI, 5'd0, 5'd8, 16'h1234), enc_i(OP_ORI, 5'd8, 5'd8, 16'h5678),
             enc_i(OP_LUI, 5'd0, 5'd9, 16'h7654), enc_i(OP_ORI, 5'd9, 5'd9, 16'h3210),
             32'h0109_5021, enc_r(5'd8, 5'd9, 5'd11, FN_SUBU), enc_r(5'd8, 5'd9, 5'd12, FN_SLT),
             enc_i(OP_ORI, 5'd0, 5'd13, 16'd100), enc_i(OP_LUI, 5'd0, 5'd14, 16'h1234),
             enc_i(OP_ADDI, 5'd8, 5'd15, 16'hff9c), enc_r(5'd8, 5'd9, 5'd0, FN_ADDU)};
    start();
    run(1);
    check("first_edge_status", 32'(dut.ctr.status), 32'd1);
    check("first_edge_pc", dut.PC, 32'h0000_3004);
    run(43);
    check("alu_pc", dut.PC, 32'h0000_302c);
    check("alu_status", 32'(dut.ctr.status), 32'd0);
    check("addu", dut.gpr.regs[10], 32'h8888_8888);
    check("subu", dut.gpr.regs[11], 32'h9be0_2468);
    check("slt", dut.gpr.regs[12], 32'h0000_0001);
    check("ori", dut.gpr.regs[13], 32'h0000_0064);
    check("lui", dut.gpr.regs[14], 32'h1234_0000);
    check("addi_neg", dut.gpr.regs[15], 32'h1234_5614);
    check("addi_neg_flag", dut.gpr.regs[30], 32'h0);
    check("r0_write_ignored", dut.gpr.regs[0], 32'h0);

    // asynchronous reset taken in the middle of an instruction
    run(1);
    check("pre_reset_status", 32'(dut.ctr.status), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'h0000_3000);
    check("rst_status", 32'(dut.ctr.status), 32'd0);
    check("rst_ir", dut.instruction, 32'h0);
    check("rst_r10", dut.gpr.regs[10], 32'h0);
    check("rst_r8", dut.gpr.regs[8], 32'h0);
    check("rst_im_kept", {24'h0, dut.ifu.im.im[0]}, 32'h0000_003c);

    // overflow flag group
    prog = '{enc_i(OP_LUI, 5'd0, 5'd8, 16'h7fff), enc_i(OP_ORI, 5'd8, 5'd8, 16'hffff),
             enc_i(OP_ADDIU, 5'd8, 5'd11, 16'd100), enc_i(OP_ADDI, 5'd8, 5'd10, 16'd100),
             enc_i(OP_ADDI, 5'd0, 5'd12, 16'hfffb)};
    start();
    run(12);
    check("addiu_wrap", dut.gpr.regs[11], 32'h8000_0063);
    check("addiu_no_flag", dut.gpr.regs[30], 32'h0);
    run(4);
    check("addi_ovf_rt_kept", dut.gpr.regs[10], 32'h0);
    check("addi_ovf_flag", dut.gpr.regs[30], 32'h1);
    run(4);
    check("addi_neg5", dut.gpr.regs[12], 32'hffff_fffb);
    check("addi_flag_clear", dut.gpr.regs[30], 32'h0);
    check("flag_pc", dut.PC, 32'h0000_3014);

    // memory group
    prog = '{enc_i(OP_ORI, 5'd0, 5'd8, 16'd24), enc_i(OP_LUI, 5'd0, 5'd9, 16'h1234),
             enc_i(OP_ORI, 5'd9, 5'd9, 16'h5678), enc_i(OP_SW, 5'd8, 5'd9, 16'd4),
             enc_i(OP_LW, 5'd8, 5'd10, 16'd4), enc_i(OP_LUI, 5'd0, 5'd9, 16'h3456),
             enc_i(OP_ORI, 5'd9, 5'd9, 16'h7890), enc_i(OP_SW, 5'd8, 5'd9, 16'hfff8)};
    start();
    run(16);
    check("sw_pc", dut.PC, 32'h0000_3010);
    check("sw_byte_lsb", {24'h0, dut.dm.dm[28]}, 32'h0000_0078);
    check("sw_byte_msb", {24'h0, dut.dm.dm[31]}, 32'h0000_0012);
    run(4);
    check("lw_s5_status", 32'(dut.ctr.status), 32'd4);
    check("lw_not_yet", dut.gpr.regs[10], 32'h0);
    run(1);
    check("lw_data", dut.gpr.regs[10], 32'h1234_5678);
    check("lw_status", 32'(dut.ctr.status), 32'd0);
    run(12);
    check("sw_neg_word", {dut.dm.dm[19], dut.dm.dm[18], dut.dm.dm[17], dut.dm.dm[16]}, 32'h3456_7890);
    check("mem_pc", dut.PC, 32'h0000_3020);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_dm_kept", {24'h0, dut.dm.dm[16]}, 32'h0000_0090);

    // control-transfer group
    prog = '{32'h1109_0002};
    start();
    run(2);
    check("beq_taken_pc", dut.PC, 32'h0000_300c);
    check("beq_status", 32'(dut.ctr.status), 32'd0);

    prog = '{enc_i(OP_ORI, 5'd0, 5'd9, 16'd1), 32'h1109_0002};
    start();
    run(6);
    check("beq_not_taken_pc", dut.PC, 32'h0000_3008);

    prog = '{32'h0000_0000};
    start();
    run(2);
    check("nop_pc", dut.PC, 32'h0000_3004);

    prog = '{32'h0800_0c08};
    start();
    run(2);
    check("j_pc", dut.PC, 32'h0000_3020);

    prog = '{32'h0c00_0c08};
    start();
    run(2);
    check("jal_pc", dut.PC, 32'h0000_3020);
    check("jal_r31", dut.gpr.regs[31], 32'h0000_3004);

    prog = '{enc_i(OP_LUI, 5'd0, 5'd8, 16'h1234), enc_i(OP_ORI, 5'd8, 5'd8, 16'h5678),
             32'h0100_0008};
    start();
    run(10);
    check("jr_pc", dut.PC, 32'h1234_5678);

    prog = '{32'hfd0a_0064};
    start();
    run(2);
    check("unknown_pc", dut.PC, 32'h0000_3004);
    check("unknown_status", 32'(dut.ctr.status), 32'd0);
    check("unknown_no_write", dut.gpr.regs[10], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
